// File: rtl/app_line_buffer_pkg.sv
// Shared types and defaults for the application-side line buffer.
package app_line_buffer_pkg;

  // Two-state controller: collect a line, then release it as one burst.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } lb_state_e;

  // Carriage return ends a line by default.
  localparam logic [7:0]  TERM_CHAR_DEF      = 8'h0D;
  // 1 ms of idle at 48 MHz before a partial line is pushed out.
  localparam int unsigned TIMEOUT_CYCLES_DEF = 48000;

endpackage

// File: rtl/app_line_buffer_if.sv
// Byte-stream pair between bulk_endp (master) and the line buffer (slave).
interface app_line_buffer_if;
  // OUT stream: endpoint -> buffer
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  // IN stream: buffer -> endpoint
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  modport slave (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );
endinterface

// File: rtl/app_idle_timer.sv
// Saturating idle counter with synchronous clear; expired_o is high while
// the count sits at TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 disables it.
module app_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          ENA  = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && ENA && (cnt_q != LAST))
      cnt_d = cnt_q + TW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = ENA && (cnt_q == LAST);

endmodule

// File: rtl/app_line_buffer.sv
// Store-and-forward line buffer: collects OUT bytes, then releases them as
// one IN burst on terminator, full buffer, idle timeout or flush.
module app_line_buffer
  import app_line_buffer_pkg::*;
#(
  parameter int unsigned DEPTH          = 64,
  parameter logic [7:0]  TERM_CHAR      = TERM_CHAR_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  app_line_buffer_if.slave       bus,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  lb_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [DEPTH];

  logic          out_ready, in_valid;
  logic [7:0]    in_data;
  logic          acc, wr_en;
  logic [LW-1:0] level_inc;
  logic          tmr_clr, tmr_en, tmr_exp;

  app_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(tmr_exp)
  );

  // Next-state, pointer/level updates and stream outputs.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    acc       = 1'b0;
    wr_en     = 1'b0;
    level_inc = level_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        out_ready = (level_q < FULL);
        acc       = bus.out_valid && out_ready;
        level_inc = level_q + (acc ? LW'(1) : LW'(0));
        if (acc) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          level_d  = level_inc;
          tmr_clr  = 1'b1;
        end else if (level_q != '0) begin
          tmr_en = 1'b1;
        end
        // All release causes collapse into one transition; the byte taken
        // this cycle is already counted in level_inc and goes out too.
        if ((acc && (bus.out_data == TERM_CHAR)) ||
            (level_inc == FULL) ||
            (flush_i && (level_inc != '0)) ||
            (tmr_exp && (level_q != '0))) begin
          state_d = ST_DRAIN;
          tmr_clr = 1'b1;
        end
      end
      ST_DRAIN: begin
        in_valid = 1'b1;
        in_data  = mem_q[rd_ptr_q];
        tmr_clr  = 1'b1;
        if (bus.in_ready) begin
          if (level_q == LW'(1)) begin
            // Last byte gone: rewind so pointers never wrap.
            state_d  = ST_FILL;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            level_d  = level_q - LW'(1);
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Byte storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.out_data;
  end

  assign bus.out_ready = out_ready;
  assign bus.in_valid  = in_valid;
  assign bus.in_data   = in_data;
  assign level_o       = level_q;
  assign busy_o        = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_app_line_buffer.sv
// Directed bench for app_line_buffer: line echo, full buffer, idle timeout,
// flush, stalled drain and reset during drain.
module tb_app_line_buffer;

  localparam int DEPTH = 64;
  localparam int TOUT  = 100;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic [6:0] level;
  logic       busy;

  app_line_buffer_if bus();

  app_line_buffer #(
    .DEPTH         (DEPTH),
    .TERM_CHAR     (8'h0D),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus),
    .flush_i(flush),
    .level_o(level),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] got[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Offer one byte from a negedge; returns on the negedge after it is taken.
  task automatic push(input logic [7:0] b);
    int g = 0;
    bus.out_data  = b;
    bus.out_valid = 1'b1;
    while (!bus.out_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!bus.out_ready) check("push_ready", {31'd0, bus.out_ready}, 1);
    @(negedge clk);
    bus.out_valid = 1'b0;
  endtask

  // Consume a burst with a repeating 4-cycle in_ready pattern (bit 0 first),
  // checking hold-while-stalled and that OUT stays closed.
  task automatic drain(input logic [3:0] pat, input int maxc);
    logic       pv = 1'b0, pr = 1'b1;
    logic [7:0] pd = 8'h00;
    int c = 0;
    got.delete();
    while (busy && c < maxc) begin
      if (pv && !pr) begin
        check("hold_valid", {31'd0, bus.in_valid}, 1);
        check("hold_data", {24'd0, bus.in_data}, {24'd0, pd});
      end
      check("drain_out_ready", {31'd0, bus.out_ready}, 0);
      bus.in_ready = pat[c % 4];
      if (bus.in_valid && bus.in_ready) got.push_back(bus.in_data);
      pv = bus.in_valid; pr = bus.in_ready; pd = bus.in_data;
      @(negedge clk);
      c++;
    end
    bus.in_ready = 1'b0;
    check("drain_end_busy", {31'd0, busy}, 0);
    check("drain_end_valid", {31'd0, bus.in_valid}, 0);
    check("drain_end_level", {25'd0, level}, 0);
  endtask

  task automatic expect_got(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input int n);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    check({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check({tag, "_byte"}, {24'd0, got[i]}, {24'd0, e[i]});
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0;
    bus.out_data = 8'h00; bus.out_valid = 1'b0; bus.in_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_out_ready", {31'd0, bus.out_ready}, 1);
    check("rst_in_valid", {31'd0, bus.in_valid}, 0);
    check("rst_in_data", {24'd0, bus.in_data}, 0);
    check("rst_level", {25'd0, level}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Terminated line: valid one cycle after the CR is taken
    push(8'h41); push(8'h42); push(8'h0D);
    check("t1_valid", {31'd0, bus.in_valid}, 1);
    check("t1_first", {24'd0, bus.in_data}, 32'h41);
    check("t1_level", {25'd0, level}, 3);
    check("t1_busy", {31'd0, busy}, 1);
    drain(4'b1111, 50);
    expect_got("t1", 8'h41, 8'h42, 8'h0D, 3);

    // Full buffer: 0x40..0x7F keeps CR out of the data
    for (int i = 0; i < DEPTH - 1; i++) push(8'(8'h40 + i));
    check("t2_level63", {25'd0, level}, 63);
    check("t2_ready63", {31'd0, bus.out_ready}, 1);
    check("t2_busy63", {31'd0, busy}, 0);
    push(8'h7F);
    check("t2_level64", {25'd0, level}, 64);
    check("t2_ready64", {31'd0, bus.out_ready}, 0);
    check("t2_busy64", {31'd0, busy}, 1);
    drain(4'b1111, 200);
    check("t2_len", got.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got.size(); i++)
      check("t2_byte", {24'd0, got[i]}, 32'h40 + i);

    // Idle timeout: drain exactly TOUT cycles after the last accept
    push(8'h31); push(8'h32); push(8'h33);
    begin
      int k = 0;
      while (!busy && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("t3_timeout_cycles", k, TOUT);
    end
    drain(4'b1111, 50);
    expect_got("t3", 8'h31, 8'h32, 8'h33, 3);
    begin
      int nb = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (busy) nb++;
      end
      check("t3_empty_idle_busy", nb, 0);
    end

    // Flush with data, then flush while empty
    push(8'h61); push(8'h62);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_busy", {31'd0, busy}, 1);
    check("t4_first", {24'd0, bus.in_data}, 32'h61);
    drain(4'b1111, 50);
    expect_got("t4", 8'h61, 8'h62, 8'h00, 2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_empty_flush_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    check("t4_empty_flush_busy_later", {31'd0, busy}, 0);

    // Stalled drain with OUT traffic pending
    push(8'h71); push(8'h72); push(8'h0D);
    bus.out_data = 8'h55; bus.out_valid = 1'b1;
    drain(4'b1001, 100);
    expect_got("t5", 8'h71, 8'h72, 8'h0D, 3);
    @(negedge clk);
    bus.out_valid = 1'b0;
    check("t5_55_taken_in_fill", {25'd0, level}, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drain(4'b1111, 50);
    expect_got("t5b", 8'h55, 8'h00, 8'h00, 1);

    // Reset in the middle of a drain
    push(8'h41); push(8'h42); push(8'h0D);
    bus.in_ready = 1'b1;
    @(negedge clk);
    bus.in_ready = 1'b0;
    check("t6_pending", {25'd0, level}, 2);
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, bus.in_valid}, 0);
    check("t6_rst_level", {25'd0, level}, 0);
    check("t6_rst_ready", {31'd0, bus.out_ready}, 1);
    check("t6_rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    push(8'h5A); push(8'h0D);
    drain(4'b1111, 50);
    expect_got("t6", 8'h5A, 8'h0D, 8'h00, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
